// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared load/store port types and data-memory responder definitions
// Request/response structs for the core memory port plus the responder FSM states.
package dmem_responder_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        wen;
    logic        byte_not_word;
  } dmem_req_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmem_resp_state_e;

  localparam int dmem_lat_width_gp = 4;

  // Little-endian lane select: lane 0 is bits 7:0.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    b = word[7:0];
    case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM with byte write enables and registered read
// Read data updates only on enabled cycles, so it holds the last access result indefinitely.
module dmem_ram #(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    i_en,
  input  logic [3:0]              i_be,
  input  logic [addr_width_p-1:0] i_addr,
  input  logic [31:0]             i_wdata,
  output logic [31:0]             o_rdata
);

  logic [31:0] r_mem [0:(1<<addr_width_p)-1];

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - valid/yumi data-memory slave with configurable response latency
// Controller FSM, byte-lane steering and out-of-range detection around dmem_ram.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [dmem_lat_width_gp-1:0] lp_lat = dmem_lat_width_gp'(latency_p);

  dmem_resp_state_e             r_state;
  dmem_resp_state_e             w_next;
  dmem_req_state                r_req;
  logic [dmem_lat_width_gp-1:0] r_cnt;
  logic                         r_first;
  logic                         r_rd_ok;

  logic                         w_oor;
  logic [1:0]                   w_lane;
  logic [addr_width_p-1:0]      w_word;
  logic                         w_ram_en;
  logic [3:0]                   w_ram_be;
  logic [31:0]                  w_ram_wdata;
  logic [31:0]                  w_ram_rdata;
  logic [31:0]                  w_steered;

  // Any address bit above the RAM's byte span marks the access out of range.
  assign w_oor       = (r_req.addr >> (addr_width_p + 2)) != 32'd0;
  assign w_lane      = r_req.addr[1:0];
  assign w_word      = r_req.addr[addr_width_p+1:2];
  assign w_ram_en    = (r_state == ACK) && !w_oor;
  assign w_ram_be    = !r_req.wen           ? 4'h0 :
                       r_req.byte_not_word  ? (4'b0001 << w_lane) : 4'hf;
  assign w_ram_wdata = r_req.byte_not_word ? {4{r_req.write_data[7:0]}} : r_req.write_data;
  assign w_steered   = r_req.byte_not_word ? {24'h0, lane_byte(w_ram_rdata, w_lane)} : w_ram_rdata;

  dmem_ram #(
    .addr_width_p(addr_width_p)
  ) u_ram (
    .clk    (clk),
    .i_en   (w_ram_en),
    .i_be   (w_ram_be),
    .i_addr (w_word),
    .i_wdata(w_ram_wdata),
    .o_rdata(w_ram_rdata)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next == RESP) && (r_state != RESP);
      if (r_state == IDLE && to_mem_i.valid) begin
        r_req.addr          <= addr_i;
        r_req.write_data    <= to_mem_i.write_data;
        r_req.wen           <= to_mem_i.wen;
        r_req.byte_not_word <= to_mem_i.byte_not_word;
      end
      if (r_state == ACK) begin
        r_cnt   <= lp_lat;
        r_rd_ok <= !r_req.wen && !w_oor;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    from_mem_o = '0;
    busy_o     = (r_state != IDLE);
    err_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (to_mem_i.valid) w_next = ACK;
      end
      ACK: begin
        from_mem_o.yumi = 1'b1;
        w_next = (lp_lat != '0) ? WAIT : RESP;
      end
      WAIT: begin
        if (r_cnt == dmem_lat_width_gp'(1)) w_next = RESP;
      end
      RESP: begin
        from_mem_o.valid     = 1'b1;
        // RAM output only moves on enabled cycles, so it is stable for the whole RESP phase.
        from_mem_o.read_data = r_rd_ok ? w_steered : 32'h0;
        err_o                = r_first && w_oor;
        if (to_mem_i.yumi) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
